makestuff_tlp_tx_arbiter: RTL and testbench
===========================================

# makestuff_tlp_tx_arbiter

Packet-granular two-way arbiter that shares the single PCIe TLP transmit stream between two independent TLP sources: port A (completions / register-read responses) and port B (FPGA→CPU DMA write TLPs). It sits between the TLP sender logic and the hard-IP tx interface. Once a packet is granted, the arbiter holds that grant until EOP, drives the tx stream through one registered output stage, and counts packets and framing errors per port.

## Interface
- CNT_WIDTH, 16, width of each per-port packet counter.
- pcieClk_in  input  1  125MHz core clock; all logic on rising edge.
- pcieRst_n_in  input  1  one clock; reset is synchronous and active-low.
- aData_in  input  64  port A beat (makestuff_tlp_xcvr_pkg::uint64).
- aValid_in / aReady_out  input / output  1  port A valid/ready handshake.
- aSOP_in / aEOP_in  input  1  port A start/end of packet, qualified by aValid_in.
- bData_in, bValid_in, bReady_out, bSOP_in, bEOP_in: same as port A, for port B.
- txData_out  output  64  tx beat to hard IP.
- txValid_out / txReady_in  output / input  1  tx handshake.
- txSOP_out / txEOP_out  output  1  tx framing.
- aPktCount_out / bPktCount_out  output  CNT_WIDTH  packets forwarded per port.
- framingErr_out  output  1  sticky; set on any framing violation.
- busy_out  output  1  high while state ≠ IDLE.

## Operation
- States: IDLE, OWN_A, OWN_B.
- IDLE:
  - A valid with SOP, B not → grant A.
  - B valid with SOP, A not → grant B.
  - Both valid with SOP → grant the port that is not lastGrant, i.e. round-robin.
  - The granted beat is accepted in the same cycle, subject to output-stage space.
  - Accepting a beat with SOP and no EOP → OWN_x. SOP and EOP together (single-beat TLP) → stay IDLE.
  - lastGrant updates on every accepted SOP beat.
- OWN_x:
  - Only port x sees ready; the other port's ready is 0.
  - An accepted beat with EOP → IDLE.
  - Interleaving between ports is never permitted.
- Framing violations:
  - Port valid without SOP while IDLE, when no other port is eligible: the beat is accepted and discarded (ready=1, no tx), and framingErr_out is set.
  - SOP beat from the owner while in OWN_x: forwarded as-is; framingErr_out is set; the grant is unchanged.
- Counters:
  - The port counter increments on every forwarded beat with EOP.
  - Counters wrap modulo 2^CNT_WIDTH.
  - Discarded beats are not counted.
- Output stage: one register holding data, SOP, EOP and valid.
  - The stage has space when it is empty or txReady_in=1.
  - xReady_out = grant(x) && space. This is a combinational path from txReady_in.
  - A beat sits in the register while txReady_in=0; data and framing are held stable until accepted.

## Timing
- Reset (pcieRst_n_in=0 at a clock edge): state=IDLE, lastGrant=B (so A wins the first tie), output register empty.
  - txValid_out=0, txSOP_out=0, txEOP_out=0, txData_out=0.
  - Both counters 0, framingErr_out=0, busy_out=0, aReady_out=bReady_out=0 during reset.
- Reset mid-packet: the partial packet is dropped, including any beat in the output register. No EOP is synthesised.
- Latency: a source beat accepted at edge N appears on tx from cycle N+1.
- Full throughput: with txReady_in held at 1, one beat per cycle, including back-to-back packets from alternating ports. There is no idle cycle between an EOP and the next SOP.
- A tie seen in the same cycle that an EOP leaves OWN_x is not arbitrated until the next cycle. The EOP cycle completes the transition to IDLE; arbitration happens in IDLE.
- Counter and framingErr_out updates are visible the cycle after the triggering accept.

## Structure
- Shared typedefs live in makestuff_tlp_xcvr_pkg:
  - uint64 (existing).
  - New TxArbState enum {IDLE, OWN_A, OWN_B}.
  - New TxPort enum {PORT_A, PORT_B}.
- One sub-module, makestuff_tlp_tx_oreg: the single-entry registered output stage with a space output.
- The arbiter FSM, counters and error logic stay in the top module.

## Test plan
- Single-beat A TLP, data 0x0123456789ABCDEF, SOP=EOP=1, txReady_in=1 → on tx next cycle with SOP=EOP=1; aPktCount_out=1.
- A and B both present 3-beat packets at SOP in the same cycle after reset → A's 3 beats, then B's 3 beats back-to-back; bReady_out=0 during A's packet.
- txReady_in low for 4 cycles mid-packet → txData_out and framing stable; source ready low; no beat lost or duplicated.
- B sends a beat with SOP=0 while IDLE → beat dropped, no tx activity, framingErr_out=1 and sticky; bPktCount_out unchanged.
- Reset asserted during beat 2 of a 4-beat A packet → all outputs return to reset values next cycle; the next B packet is forwarded cleanly.
- 65536 single-beat A packets with CNT_WIDTH=16 → aPktCount_out wraps to 0.

Source files
------------

// File: rtl/makestuff_tlp_xcvr_pkg.sv
// makestuff_tlp_xcvr_pkg: shared types for the TLP transceiver blocks
package makestuff_tlp_xcvr_pkg;
  typedef logic [63:0] uint64;
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} TxArbState;
  typedef enum logic {PORT_A, PORT_B} TxPort;
endpackage

// File: rtl/makestuff_tlp_tx_oreg.sv
// makestuff_tlp_tx_oreg: single-entry registered tx stage; beat held until tx_ready
module makestuff_tlp_tx_oreg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        space,
  output logic [63:0] tx_data,
  output logic        tx_valid,
  output logic        tx_sop,
  output logic        tx_eop,
  input  logic        tx_ready
);
  assign space = !tx_valid || tx_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_sop <= 1'b0;
      tx_eop <= 1'b0;
      tx_data <= '0;
    end else if (space) begin
      tx_valid <= in_valid;
      tx_sop <= in_valid && in_sop;
      tx_eop <= in_valid && in_eop;
      if (in_valid) tx_data <= in_data;
    end
  end
endmodule

// File: rtl/makestuff_tlp_tx_arbiter.sv
// makestuff_tlp_tx_arbiter: packet-granular round-robin arbiter of two TLP sources
// onto one tx stream, with per-port packet counters and sticky framing error.
module makestuff_tlp_tx_arbiter
  import makestuff_tlp_xcvr_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 pcieClk_in,
  input  logic                 pcieRst_n_in,
  input  logic [63:0]          aData_in,
  input  logic                 aValid_in,
  output logic                 aReady_out,
  input  logic                 aSOP_in,
  input  logic                 aEOP_in,
  input  logic [63:0]          bData_in,
  input  logic                 bValid_in,
  output logic                 bReady_out,
  input  logic                 bSOP_in,
  input  logic                 bEOP_in,
  output logic [63:0]          txData_out,
  output logic                 txValid_out,
  input  logic                 txReady_in,
  output logic                 txSOP_out,
  output logic                 txEOP_out,
  output logic [CNT_WIDTH-1:0] aPktCount_out,
  output logic [CNT_WIDTH-1:0] bPktCount_out,
  output logic                 framingErr_out,
  output logic                 busy_out
);
  TxArbState state, state_next;
  TxPort last_grant;
  logic space, a_sop, b_sop;
  logic grant_a, grant_b, drop_a, drop_b, fwd_a, fwd_b, fwd_sop, fwd_eop;
  assign a_sop = aValid_in && aSOP_in;
  assign b_sop = bValid_in && bSOP_in;
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    drop_a = 1'b0;
    drop_b = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        grant_a = a_sop && (!b_sop || last_grant == PORT_B);
        grant_b = b_sop && (!a_sop || last_grant == PORT_A);
        // a headless beat is only swallowed when nobody has a real packet waiting
        drop_a = aValid_in && !a_sop && !b_sop;
        drop_b = bValid_in && !b_sop && !a_sop && !aValid_in;
      end
      OWN_A: grant_a = 1'b1;
      OWN_B: grant_b = 1'b1;
      default: ;
    endcase
    fwd_a = grant_a && aValid_in && space;
    fwd_b = grant_b && bValid_in && space;
    fwd_sop = grant_a ? aSOP_in : bSOP_in;
    fwd_eop = grant_a ? aEOP_in : bEOP_in;
    case (state)
      IDLE: state_next = (fwd_a && !aEOP_in) ? OWN_A : (fwd_b && !bEOP_in) ? OWN_B : IDLE;
      OWN_A: state_next = (fwd_a && aEOP_in) ? IDLE : OWN_A;
      OWN_B: state_next = (fwd_b && bEOP_in) ? IDLE : OWN_B;
      default: state_next = IDLE;
    endcase
  end
  assign aReady_out = pcieRst_n_in && (drop_a || (grant_a && space));
  assign bReady_out = pcieRst_n_in && (drop_b || (grant_b && space));
  assign busy_out = state != IDLE;
  always_ff @(posedge pcieClk_in) begin
    if (!pcieRst_n_in) begin
      state <= IDLE;
      last_grant <= PORT_B;
      aPktCount_out <= '0;
      bPktCount_out <= '0;
      framingErr_out <= 1'b0;
    end else begin
      state <= state_next;
      if ((fwd_a || fwd_b) && fwd_sop) last_grant <= fwd_a ? PORT_A : PORT_B;
      if (fwd_a && aEOP_in) aPktCount_out <= aPktCount_out + CNT_WIDTH'(1);
      if (fwd_b && bEOP_in) bPktCount_out <= bPktCount_out + CNT_WIDTH'(1);
      if (drop_a || drop_b || (state != IDLE && (fwd_a || fwd_b) && fwd_sop)) framingErr_out <= 1'b1;
    end
  end
  makestuff_tlp_tx_oreg oreg (
    .clk(pcieClk_in),
    .rst_n(pcieRst_n_in),
    .in_valid(fwd_a || fwd_b),
    .in_data(grant_a ? aData_in : bData_in),
    .in_sop(fwd_sop),
    .in_eop(fwd_eop),
    .space(space),
    .tx_data(txData_out),
    .tx_valid(txValid_out),
    .tx_sop(txSOP_out),
    .tx_eop(txEOP_out),
    .tx_ready(txReady_in)
  );
endmodule

// File: tb/tb_makestuff_tlp_tx_arbiter.sv
// tb_makestuff_tlp_tx_arbiter: vector table, hand sequences, and randomized
// packet traffic checked against a per-port queue model of the tx stream.
module tb_makestuff_tlp_tx_arbiter;
  localparam logic [63:0] DA = 64'hA000_0000_0000_0000;
  localparam logic [63:0] DB = 64'hB000_0000_0000_0000;
  localparam logic [63:0] DC = 64'h0123_4567_89AB_CDEF;
  logic clk = 1'b0, rst_n = 1'b0, tr = 1'b1;
  logic v [2], s [2], e [2];
  logic [63:0] d [2];
  logic ar, br, tx_v, tx_s, tx_e, err, busy;
  logic [63:0] tx_data;
  logic [15:0] acnt, bcnt;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  makestuff_tlp_tx_arbiter #(.CNT_WIDTH(16)) dut (
    .pcieClk_in(clk), .pcieRst_n_in(rst_n),
    .aData_in(d[0]), .aValid_in(v[0]), .aReady_out(ar), .aSOP_in(s[0]), .aEOP_in(e[0]),
    .bData_in(d[1]), .bValid_in(v[1]), .bReady_out(br), .bSOP_in(s[1]), .bEOP_in(e[1]),
    .txData_out(tx_data), .txValid_out(tx_v), .txReady_in(tr), .txSOP_out(tx_s), .txEOP_out(tx_e),
    .aPktCount_out(acnt), .bPktCount_out(bcnt), .framingErr_out(err), .busy_out(busy)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0; s[p] = 1'b0; e[p] = 1'b0; d[p] = '0;
    end
  endtask
  typedef struct {
    logic [2:0]  a;
    logic [63:0] ad;
    logic [2:0]  b;
    logic [63:0] bd;
    logic        tr;
    logic [4:0]  flags;
    logic [63:0] etd;
    logic [15:0] ea, eb;
    logic        eerr, ebusy;
  } vec_t;
  function automatic vec_t mk(logic [2:0] a, logic [63:0] ad, logic [2:0] b, logic [63:0] bd,
                              logic t, logic [4:0] f, logic [63:0] etd, logic [15:0] ea,
                              logic [15:0] eb, logic eerr, logic ebusy);
    mk = '{a, ad, b, bd, t, f, etd, ea, eb, eerr, ebusy};
  endfunction
  vec_t tv [23];
  // queue model of the tx stream: each port's accepted beats must emerge in order, whole packets at a time
  logic rnd_on = 1'b0, held = 1'b0;
  logic [66:0] held_beat;
  logic acc [2];
  logic [65:0] q0 [$];
  logic [65:0] q1 [$];
  logic [15:0] exp_cnt [2];
  int owner = -1, pp;
  always @(negedge clk) if (rnd_on) begin
    chk("random pkt counters", {acnt, bcnt}, {exp_cnt[0], exp_cnt[1]});
    if (held) chk("tx held stable", {tx_v, tx_data, tx_s, tx_e}, held_beat);
    held = tx_v && !tr;
    held_beat = {1'b1, tx_data, tx_s, tx_e};
    if (tx_v && tr) begin
      pp = tx_data[63] ? 1 : 0;
      if (owner >= 0) chk("no interleave", 128'(pp), 128'(owner));
      chk("tx beat was queued", ((pp == 1) ? q1.size() : q0.size()) != 0, 1'b1);
      if (pp == 1 && q1.size() != 0) chk("tx beat B", {tx_data, tx_s, tx_e}, q1.pop_front());
      if (pp == 0 && q0.size() != 0) chk("tx beat A", {tx_data, tx_s, tx_e}, q0.pop_front());
      owner = tx_e ? -1 : pp;
    end
    acc[0] = v[0] && ar;
    acc[1] = v[1] && br;
    if (acc[0]) q0.push_back({d[0], s[0], e[0]});
    if (acc[1]) q1.push_back({d[1], s[1], e[1]});
    for (int p = 0; p < 2; p++) if (acc[p] && e[p]) exp_cnt[p] = exp_cnt[p] + 16'd1;
  end
  int rem [2], seq [2];
  logic prep [2];
  initial begin
    tv[0]  = mk(3'b110, DA|0, 3'b110, DB|0, 1, 5'b10000, 0, 0, 0, 0, 0);
    tv[1]  = mk(3'b100, DA|1, 3'b110, DB|0, 1, 5'b10110, DA|0, 0, 0, 0, 1);
    tv[2]  = mk(3'b101, DA|2, 3'b110, DB|0, 1, 5'b10100, DA|1, 0, 0, 0, 1);
    tv[3]  = mk(3'b000, 0, 3'b110, DB|0, 1, 5'b01101, DA|2, 1, 0, 0, 0);
    tv[4]  = mk(3'b000, 0, 3'b100, DB|4, 1, 5'b01110, DB|0, 1, 0, 0, 1);
    tv[5]  = mk(3'b000, 0, 3'b101, DB|5, 1, 5'b01100, DB|4, 1, 0, 0, 1);
    tv[6]  = mk(3'b111, DC, 3'b000, 0, 1, 5'b10101, DB|5, 1, 1, 0, 0);
    tv[7]  = mk(3'b000, 0, 3'b000, 0, 1, 5'b00111, DC, 2, 1, 0, 0);
    tv[8]  = mk(3'b110, DA|8, 3'b000, 0, 1, 5'b10000, 0, 2, 1, 0, 0);
    for (int i = 9; i < 13; i++) tv[i] = mk(3'b100, DA|9, 3'b000, 0, 0, 5'b00110, DA|8, 2, 1, 0, 1);
    tv[13] = mk(3'b100, DA|9, 3'b000, 0, 1, 5'b10110, DA|8, 2, 1, 0, 1);
    tv[14] = mk(3'b101, DA|14, 3'b000, 0, 1, 5'b10100, DA|9, 2, 1, 0, 1);
    tv[15] = mk(3'b000, 0, 3'b000, 0, 1, 5'b00101, DA|14, 3, 1, 0, 0);
    tv[16] = mk(3'b000, 0, 3'b100, DB|16, 1, 5'b01000, 0, 3, 1, 0, 0);
    tv[17] = mk(3'b000, 0, 3'b000, 0, 1, 5'b00000, 0, 3, 1, 1, 0);
    tv[18] = mk(3'b000, 0, 3'b000, 0, 1, 5'b00000, 0, 3, 1, 1, 0);
    tv[19] = mk(3'b000, 0, 3'b110, DB|19, 1, 5'b01000, 0, 3, 1, 1, 0);
    tv[20] = mk(3'b000, 0, 3'b110, DB|20, 1, 5'b01110, DB|19, 3, 1, 1, 1);
    tv[21] = mk(3'b000, 0, 3'b101, DB|21, 1, 5'b01110, DB|20, 3, 1, 1, 1);
    tv[22] = mk(3'b000, 0, 3'b000, 0, 1, 5'b00101, DB|21, 3, 2, 1, 0);
    // reset with both sources offering packets: readies must stay low
    idle_inputs();
    v[0] = 1; s[0] = 1; v[1] = 1; s[1] = 1;
    tick(); tick();
    @(negedge clk);
    chk("reset readies", {ar, br}, 2'b00);
    chk("reset outputs", {tx_v, tx_s, tx_e, tx_data, acnt, bcnt, err, busy}, '0);
    tick();
    rst_n = 1'b1;
    foreach (tv[i]) begin
      {v[0], s[0], e[0]} = tv[i].a; d[0] = tv[i].ad;
      {v[1], s[1], e[1]} = tv[i].b; d[1] = tv[i].bd;
      tr = tv[i].tr;
      @(negedge clk);
      chk($sformatf("row%0d ready/tx flags", i), {ar, br, tx_v, tx_s, tx_e}, tv[i].flags);
      if (tv[i].flags[2]) chk($sformatf("row%0d tx data", i), tx_data, tv[i].etd);
      chk($sformatf("row%0d cnt/err/busy", i), {acnt, bcnt, err, busy}, {tv[i].ea, tv[i].eb, tv[i].eerr, tv[i].ebusy});
      tick();
    end
    // reset lands on beat 2 of an A packet; then a clean B packet
    idle_inputs();
    tr = 1;
    v[0] = 1; s[0] = 1; d[0] = DA|64'h40;
    @(negedge clk);
    chk("midpkt A sop ready", ar, 1'b1);
    tick();
    s[0] = 0; d[0] = DA|64'h41; rst_n = 1'b0;
    @(negedge clk);
    chk("midpkt readies in reset", {ar, br}, 2'b00);
    tick();
    rst_n = 1'b1;
    idle_inputs();
    v[1] = 1; s[1] = 1; d[1] = DB|64'h50;
    @(negedge clk);
    chk("after midpkt reset outputs", {tx_v, tx_s, tx_e, tx_data, acnt, bcnt, err, busy}, '0);
    chk("after midpkt reset B ready", {ar, br}, 2'b01);
    tick();
    s[1] = 0; e[1] = 1; d[1] = DB|64'h51;
    @(negedge clk);
    chk("B after reset beat0", {tx_v, tx_s, tx_e, tx_data}, {3'b110, DB|64'h50});
    tick();
    idle_inputs();
    @(negedge clk);
    chk("B after reset beat1", {tx_v, tx_s, tx_e, tx_data}, {3'b101, DB|64'h51});
    chk("B after reset counts", {acnt, bcnt, err}, {16'd0, 16'd1, 1'b0});
    tick();
    // randomized traffic with random tx backpressure
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      acc[p] = 0; prep[p] = 0; rem[p] = 0; seq[p] = 0; exp_cnt[p] = '0;
    end
    rnd_on = 1'b1;
    for (int cyc = 0; cyc < 2040; cyc++) begin
      tr = (cyc >= 2000) || ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          if (rem[p] > 0) begin
            s[p] = 0; e[p] = (rem[p] == 1); d[p] = {p == 1, 63'(seq[p])}; seq[p]++; rem[p]--;
          end else prep[p] = 0;
        end
        if (!prep[p] && cyc < 1950 && $urandom_range(0, 2) == 0) begin
          rem[p] = int'($urandom_range(0, 3));
          s[p] = 1; e[p] = (rem[p] == 0); d[p] = {p == 1, 63'(seq[p])}; seq[p]++; prep[p] = 1;
        end
        v[p] = prep[p] && (cyc >= 1950 || $urandom_range(0, 3) != 0);
      end
      tick();
    end
    rnd_on = 1'b0;
    @(negedge clk);
    chk("random drain queues empty", {32'(q0.size()), 32'(q1.size())}, 64'd0);
    chk("random drain idle", {busy, err, owner == -1}, 3'b001);
    tick();
    // counter wrap: 65536 single-beat A packets
    rst_n = 1'b0;
    idle_inputs();
    tr = 1;
    tick();
    rst_n = 1'b1;
    v[0] = 1; s[0] = 1; e[0] = 1;
    for (int i = 0; i < 65536; i++) begin
      d[0] = 64'(i);
      if (i == 65535) begin
        @(negedge clk);
        chk("wrap count before last", acnt, 16'hFFFF);
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    chk("wrap count", {acnt, bcnt, err}, 33'd0);
    chk("wrap last beat", {tx_v, tx_s, tx_e, tx_data}, {3'b111, 64'd65535});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
